// File: rtl/onehot_encoder_tx.sv
// onehot_encoder_tx
// Encodes new one-hot key presses on p/q/r/s back to the 2-bit code {w,z}.
// The codes are p=11, q=10, r=01, s=00. Each code is buffered in a small FIFO
// and delivered over a valid/ready handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   p,q,r,s  one-hot key lines (codes 11, 10, 01, 00)
//   ready    consumer takes the head entry this cycle
//   err_clr  clears the sticky err/ovf flags (a same-cycle set takes priority)
//   valid    head entry available
//   w,z      head code MSB/LSB; both 0 while empty
//   err      sticky: multi-hot input seen
//   ovf      sticky: an event was dropped because the FIFO was full
//   level    FIFO occupancy
//   count    successfully pushed events, modulo 2^CNT_W
module onehot_encoder_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p,
    input  logic                     q,
    input  logic                     r,
    input  logic                     s,
    input  logic                     ready,
    input  logic                     err_clr,
    output logic                     valid,
    output logic                     w,
    output logic                     z,
    output logic                     err,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0]    FullLvl = LW'(DEPTH);
    localparam logic [LW-1:0]    LvlOne  = LW'(1);
    localparam logic [AW-1:0]    PtrOne  = AW'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [3:0]       in_q;
    logic [3:0]       last_q, last_d;
    logic [1:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             is_zero, is_one, is_multi;
    logic             push_req, push, pop, drop;
    logic             full, empty;
    logic [1:0]       code;

    always_comb begin
        is_zero  = (in_q == 4'b0000);
        // Clearing the lowest set bit leaves zero only for a single-bit value.
        is_one   = !is_zero && ((in_q & (in_q - 4'd1)) == 4'b0000);
        is_multi = !is_zero && !is_one;
        push_req = is_one && (in_q != last_q);
        code     = {in_q[3] | in_q[2], in_q[3] | in_q[1]};

        full     = (level_q == FullLvl);
        empty    = (level_q == '0);
        pop      = !empty && ready;
        // A pop in the same cycle frees the slot the push needs.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        // A dropped event still updates last so it does not retrigger.
        last_d = last_q;
        if (is_zero) begin
            last_d = 4'b0000;
        end else if (push_req) begin
            last_d = in_q;
        end

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase

        count_d = push ? count_q + CntOne : count_q;
        err_d   = is_multi | (err_q & !err_clr);
        ovf_d   = drop | (ovf_q & !err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q     <= 4'b0000;
            last_q   <= 4'b0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            in_q    <= {p, q, r, s};
            last_q  <= last_d;
            level_q <= level_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= code;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_comb begin
        valid  = !empty;
        {w, z} = empty ? 2'b00 : mem_q[rd_ptr_q];
        err    = err_q;
        ovf    = ovf_q;
        level  = level_q;
        count  = count_q;
    end

endmodule

// File: tb/tb_onehot_encoder_tx.sv
module tb_onehot_encoder_tx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst, p, q, r, s, ready, err_clr;
    logic       valid, w, z, err, ovf;
    logic [2:0] level;
    logic [7:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_in, m_last;
    logic [1:0] m_fifo[$];
    int         m_count;
    logic       m_err, m_ovf;

    onehot_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .p(p), .q(q), .r(r), .s(s),
        .ready(ready), .err_clr(err_clr), .valid(valid), .w(w), .z(z),
        .err(err), .ovf(ovf), .level(level), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] key_code(input logic [3:0] pat);
        case (pat)
            4'b1000: return 2'b11;
            4'b0100: return 2'b10;
            4'b0010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] pat);
        {p, q, r, s} = pat;
    endtask

    // One clock: the model consumes the inputs present at the edge.
    task automatic step();
        logic [3:0] cur;
        logic       rd, clr, rs, pop;
        cur = {p, q, r, s};
        rd  = ready;
        clr = err_clr;
        rs  = rst;
        @(posedge clk);
        if (rs) begin
            m_in = 4'b0; m_last = 4'b0; m_fifo.delete();
            m_count = 0; m_err = 1'b0; m_ovf = 1'b0;
        end else begin
            pop = (m_fifo.size() != 0) && rd;
            if (clr) begin
                m_err = 1'b0;
                m_ovf = 1'b0;
            end
            if (pop) void'(m_fifo.pop_front());
            case ($countones(m_in))
                0: m_last = 4'b0;
                1: if (m_in != m_last) begin
                    m_last = m_in;
                    if (m_fifo.size() < DEPTH) begin
                        m_fifo.push_back(key_code(m_in));
                        m_count = (m_count + 1) % (1 << CNT_W);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                default: m_err = 1'b1;
            endcase
            m_in = cur;
        end
        #1;
    endtask

    task automatic hold(input logic [3:0] pat, input int n);
        set_in(pat);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b0; err_clr = 1'b0; set_in(4'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if ({w, z} !== 2'b00) begin n_fail++; $display("FAIL reset_wz: got %b want 00", {w, z}); end
        // Fill three entries and raise err, then reset mid-stream.
        hold(4'b1000, 1); hold(4'b0, 1); hold(4'b0010, 1); hold(4'b0, 1);
        hold(4'b0001, 1); hold(4'b0011, 1); hold(4'b0, 2);
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL prefill_level: got %0d want 3", level); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL prefill_err: got %0b want 1", err); end
        do_reset();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %0b want 0", valid); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL midreset_level: got %0d want 0", level); end
        n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %0b want 0", err); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf: got %0b want 0", ovf); end
        n_tests++; if ({w, z} !== 2'b00) begin n_fail++; $display("FAIL midreset_wz: got %b want 00", {w, z}); end
    endtask

    task automatic test_single_press();
        do_reset();
        ready = 1'b1;
        set_in(4'b0100);
        step();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL press_early: valid got %0b want 0", valid); end
        step();
        n_tests++; if (valid !== 1'b1 || {w, z} !== 2'b10) begin n_fail++; $display("FAIL press_out: valid/wz got %0b/%b want 1/10", valid, {w, z}); end
        n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL press_count: got %0d want 1", count); end
        step();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL press_onecycle: valid got %0b want 0", valid); end
        hold(4'b0100, 3);
        n_tests++; if (valid !== 1'b0 || count !== 8'd1) begin n_fail++; $display("FAIL press_hold: valid/count got %0b/%0d want 0/1", valid, count); end
        hold(4'b0, 2);
        hold(4'b0100, 2);
        n_tests++; if (valid !== 1'b1 || {w, z} !== 2'b10 || count !== 8'd2) begin
            n_fail++; $display("FAIL press_again: valid/wz/count got %0b/%b/%0d want 1/10/2", valid, {w, z}, count);
        end
        hold(4'b0, 2);
    endtask

    task automatic test_sequence();
        logic [1:0] exp_codes [3];
        exp_codes[0] = 2'b11; exp_codes[1] = 2'b01; exp_codes[2] = 2'b00;
        do_reset();
        hold(4'b1000, 1); hold(4'b0, 1); hold(4'b0010, 1); hold(4'b0, 1);
        hold(4'b0001, 1); hold(4'b0, 2);
        n_tests++; if (level !== 3'd3 || count !== 8'd3) begin n_fail++; $display("FAIL seq_fill: level/count got %0d/%0d want 3/3", level, count); end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (valid !== 1'b1 || {w, z} !== exp_codes[i]) begin
                n_fail++; $display("FAIL seq_pop%0d: valid/wz got %0b/%b want 1/%b", i, valid, {w, z}, exp_codes[i]);
            end
            step();
        end
        n_tests++; if (valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL seq_drain: valid/level got %0b/%0d want 0/0", valid, level); end
        ready = 1'b0;
    endtask

    task automatic test_direct_change();
        do_reset();
        ready = 1'b1;
        set_in(4'b1000); step();
        set_in(4'b0100); step();
        n_tests++; if (valid !== 1'b1 || {w, z} !== 2'b11) begin n_fail++; $display("FAIL direct_first: valid/wz got %0b/%b want 1/11", valid, {w, z}); end
        set_in(4'b0); step();
        n_tests++; if (valid !== 1'b1 || {w, z} !== 2'b10 || count !== 8'd2) begin
            n_fail++; $display("FAIL direct_second: valid/wz/count got %0b/%b/%0d want 1/10/2", valid, {w, z}, count);
        end
        step();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL direct_drain: valid got %0b want 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_multi_hot();
        do_reset();
        hold(4'b1000, 1); hold(4'b0, 2);
        set_in(4'b1100); step();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL multi_early: err got %0b want 0", err); end
        set_in(4'b0); step();
        n_tests++; if (err !== 1'b1 || level !== 3'd1) begin n_fail++; $display("FAIL multi_err: err/level got %0b/%0d want 1/1", err, level); end
        step();
        n_tests++; if (level !== 3'd1 || count !== 8'd1) begin n_fail++; $display("FAIL multi_nopush: level/count got %0d/%0d want 1/1", level, count); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL multi_clr: err got %0b want 0", err); end
        set_in(4'b0011); step(); step();
        err_clr = 1'b1; step();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL multi_setwins: err got %0b want 1", err); end
        set_in(4'b0); step(); step();
        err_clr = 1'b0;
        n_tests++; if (err !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL multi_final: err/level got %0b/%0d want 0/1", err, level); end
    endtask

    task automatic test_overflow();
        logic [3:0] keys [5];
        keys[0] = 4'b1000; keys[1] = 4'b0100; keys[2] = 4'b0010;
        keys[3] = 4'b0001; keys[4] = 4'b1000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            hold(keys[i], 1);
            hold(4'b0, 1);
        end
        hold(4'b0, 1);
        n_tests++; if (level !== 3'd4 || ovf !== 1'b1 || count !== 8'd4) begin
            n_fail++; $display("FAIL ovf_full: level/ovf/count got %0d/%0b/%0d want 4/1/4", level, ovf, count);
        end
        n_tests++; if ({w, z} !== 2'b11) begin n_fail++; $display("FAIL ovf_head: wz got %b want 11", {w, z}); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: ovf got %0b want 0", ovf); end
        set_in(4'b0100); step();
        set_in(4'b0); ready = 1'b1; step(); ready = 1'b0;
        n_tests++; if (level !== 3'd4 || ovf !== 1'b0 || count !== 8'd5 || {w, z} !== 2'b10) begin
            n_fail++; $display("FAIL ovf_pushpop: level/ovf/count/wz got %0d/%0b/%0d/%b want 4/0/5/10", level, ovf, count, {w, z});
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            set_in((i % 2 == 0) ? 4'b1000 : 4'b0100);
            step();
        end
        hold(4'b0, 2);
        n_tests++; if (count !== 8'd2 || valid !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL count_wrap: count/valid/ovf got %0d/%0b/%0b want 2/0/0", count, valid, ovf);
        end
        ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] pat;
        logic [1:0] exp_wz;
        int         sel;
        do_reset();
        pat = 4'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) pat = 4'b0;
                else if (sel < 9) pat = 4'b0001 << $urandom_range(0, 3);
                else pat = 4'b1100 >> $urandom_range(0, 2);
            end
            set_in(pat);
            ready   = ($urandom_range(0, 9) < 4);
            err_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            step();
            exp_wz = (m_fifo.size() != 0) ? m_fifo[0] : 2'b00;
            n_tests++; if (valid !== (m_fifo.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, valid, m_fifo.size() != 0); end
            n_tests++; if ({w, z} !== exp_wz) begin n_fail++; $display("FAIL rnd_wz@%0d: got %b want %b", cyc, {w, z}, exp_wz); end
            n_tests++; if (int'(level) != m_fifo.size()) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, level, m_fifo.size()); end
            n_tests++; if (int'(count) != m_count) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, m_count); end
            n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %0b want %0b", cyc, err, m_err); end
            n_tests++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", cyc, ovf, m_ovf); end
        end
        rst = 1'b0; ready = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; err_clr = 1'b0; set_in(4'b0);
        m_in = 4'b0; m_last = 4'b0; m_count = 0; m_err = 1'b0; m_ovf = 1'b0;
        test_reset();
        test_single_press();
        test_sequence();
        test_direct_change();
        test_multi_hot();
        test_overflow();
        test_count_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_tx.md
Name: onehot_encoder_tx

Overview:
- Transmit-side counterpart of the team's 2-to-4 one-hot decoder. Each new one-hot pattern on p/q/r/s is encoded back to the 2-bit code {w,z}.
- Encoded events are buffered in a small FIFO and presented through a valid/ready handshake.
- Bit assignment is identical to the decoder: p=11, q=10, r=01, s=00 ({w,z}).
- Sits between lab switch/button logic and any consumer of 2-bit codes. Also flags malformed (multi-hot) input and buffer overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the accepted-event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- p  in  1  one-hot line for code 11.
- q  in  1  one-hot line for code 10.
- r  in  1  one-hot line for code 01.
- s  in  1  one-hot line for code 00.
- ready  in  1  consumer accepts the head entry this cycle.
- err_clr  in  1  clears the err and ovf sticky flags.
- valid  out  1  head entry available.
- w  out  1  head code MSB.
- z  out  1  head code LSB.
- err  out  1  sticky: multi-hot input seen.
- ovf  out  1  sticky: event dropped because the FIFO was full.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- count  out  CNT_W  accepted events, modulo 2^CNT_W.

Behaviour:
- Reset: rst high at a clk edge is one-cycle effective. It sets:
  - input stage and last-pattern register to 0000;
  - FIFO empty, so valid=0, level=0;
  - w=0, z=0, err=0, ovf=0, count=0.
  - Reset mid-stream discards all buffered entries. No partial state survives.
- Stage 1: {p,q,r,s} is registered into in_q every cycle. There is no combinational path from inputs to outputs.
- Classify in_q each cycle:
  - ZERO: no bit set. last := 0000, no push. A release between presses lets the same key be reported again.
  - ONE: exactly one bit set.
    - in_q == last: hold, no push.
    - otherwise: event. last := in_q and push the code.
  - MULTI: two or more bits set. err := 1, no push, last unchanged.
- Latency: a pattern stable before edge E0 is captured into in_q at E0 and pushed at E1. valid rises after E1 when the FIFO was empty (2 cycles input to valid).
- FIFO and handshake:
  - Pop occurs when valid && ready at a clk edge.
  - w/z always reflect the head entry. They are 0 when empty.
  - Pointers wrap modulo DEPTH.
  - ready while empty has no effect. Entries are presented oldest-first.
- Push while full without a pop in the same cycle:
  - the entry is dropped and ovf := 1;
  - last is still updated, so the dropped pattern does not retrigger;
  - count does not increment.
- Push and pop in the same cycle:
  - when full: both occur, level unchanged, no overflow;
  - when empty: the push occurs and the pop is ignored (valid was 0).
- count increments on each successful push and wraps from 2^CNT_W-1 to 0.
- err_clr clears err and ovf at the edge. If a new error condition occurs in the same cycle, set wins and the flag stays 1.
- Changing the code directly from one key to another (e.g. p to r with no release) is a new event and is pushed.

Test Plan:
- Reset mid-activity: fill 3 entries, assert rst for 1 cycle.
  - Required: next cycle valid=0, level=0, count=0, err=0, ovf=0, {w,z}=00.
- Single press, ready=1: q=1 held from cycle 0.
  - Required: valid=1 with {w,z}=10 exactly 2 cycles later for 1 cycle, count=1.
  - Holding q produces no further pushes.
  - Release, then q again: a second 10 is pushed, count=2.
- Sequence with ready=0: p, release, r, release, s.
  - Required: level=3, count=3.
  - Then ready=1 pops in order 11, 01, 00, after which valid=0.
- Direct change with no release: p then q (contiguous), ready=1.
  - Required: codes 11 then 10 delivered, count=2.
- Multi-hot input: p=q=1 for 1 cycle.
  - Required: err=1 two cycles later, level unchanged, no push.
  - err_clr pulse: err=0 next cycle.
  - Same-cycle err_clr with a new multi-hot: err stays 1.
- Overflow: DEPTH=4, ready=0, 5 distinct press/release events.
  - Required: level=4, ovf=1, count=4.
  - With the FIFO full, push and ready=1 in the same cycle: level stays 4, ovf unchanged.
